// File: rtl/deal_seq_pkg.sv
// Shared types and constants for the baccarat deal sequencer: state encoding,
// score thresholds and the rank-to-card-value helper.
package deal_seq_pkg;

    localparam int unsigned SCORE_W = 4;
    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_DEAL_P1   = 4'd0,
        ST_DEAL_D1   = 4'd1,
        ST_DEAL_P2   = 4'd2,
        ST_DEAL_D2   = 4'd3,
        ST_DECIDE    = 4'd4,
        ST_DEAL_P3   = 4'd5,
        ST_DECIDE_D3 = 4'd6,
        ST_DEAL_D3   = 4'd7,
        ST_RESULT    = 4'd8
    } state_t;

    localparam logic [SCORE_W-1:0] NATURAL_MIN      = SCORE_W'(8);
    localparam logic [SCORE_W-1:0] PLAYER_STAND_MIN = SCORE_W'(6);
    localparam logic [SCORE_W-1:0] FACE_RANK_MIN    = SCORE_W'(10);

    // Tens and face cards count as zero in baccarat.
    function automatic logic [SCORE_W-1:0] card_value(input logic [SCORE_W-1:0] rank);
        return (rank >= FACE_RANK_MIN) ? SCORE_W'(0) : rank;
    endfunction

endpackage

// File: rtl/banker_draw_rule.sv
// Banker third-card tableau: decides whether the dealer draws, given the
// dealer's two-card score and the rank of the player's third card.
module banker_draw_rule
    import deal_seq_pkg::*;
(
    input  logic [SCORE_W-1:0] dscore,
    input  logic [SCORE_W-1:0] pcard3,
    output logic               draw
);

    logic [SCORE_W-1:0] w_value;

    always_comb begin
        draw    = 1'b0;
        w_value = card_value(pcard3);
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (w_value != SCORE_W'(8));
            4'd4:             draw = (w_value >= SCORE_W'(2)) && (w_value <= SCORE_W'(7));
            4'd5:             draw = (w_value >= SCORE_W'(4)) && (w_value <= SCORE_W'(7));
            4'd6:             draw = (w_value >= SCORE_W'(6)) && (w_value <= SCORE_W'(7));
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/deal_sequencer.sv
// Baccarat deal control FSM: strobes the six card loads, applies the third-card
// rules and lights the winner. DEAL_SEQ_STATE_OUT_EN adds a state_out debug port.
module deal_sequencer
    import deal_seq_pkg::*;
(
    input  logic               slow_clock,
    input  logic               resetb,
    input  logic [SCORE_W-1:0] pscore,
    input  logic [SCORE_W-1:0] dscore,
    input  logic [SCORE_W-1:0] pcard3,
    output logic               load_pcard1,
    output logic               load_pcard2,
    output logic               load_pcard3,
    output logic               load_dcard1,
    output logic               load_dcard2,
    output logic               load_dcard3,
    output logic               player_win_light,
    output logic               dealer_win_light
`ifdef DEAL_SEQ_STATE_OUT_EN
    ,
    output logic [STATE_W-1:0] state_out
`endif
);

    state_t r_state;
    state_t w_next;
    logic   w_dealer_draw;

    banker_draw_rule u_banker_draw_rule (
        .dscore (dscore),
        .pcard3 (pcard3),
        .draw   (w_dealer_draw)
    );

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            r_state <= ST_DEAL_P1;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore output decode; lights compare the settled scores in RESULT.
    always_comb begin
        w_next           = r_state;
        load_pcard1      = 1'b0;
        load_pcard2      = 1'b0;
        load_pcard3      = 1'b0;
        load_dcard1      = 1'b0;
        load_dcard2      = 1'b0;
        load_dcard3      = 1'b0;
        player_win_light = 1'b0;
        dealer_win_light = 1'b0;
        case (r_state)
            ST_DEAL_P1: begin
                load_pcard1 = 1'b1;
                w_next      = ST_DEAL_D1;
            end
            ST_DEAL_D1: begin
                load_dcard1 = 1'b1;
                w_next      = ST_DEAL_P2;
            end
            ST_DEAL_P2: begin
                load_pcard2 = 1'b1;
                w_next      = ST_DEAL_D2;
            end
            ST_DEAL_D2: begin
                load_dcard2 = 1'b1;
                w_next      = ST_DECIDE;
            end
            ST_DECIDE: begin
                if ((pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN)) begin
                    w_next = ST_RESULT;
                end else if (pscore < PLAYER_STAND_MIN) begin
                    w_next = ST_DEAL_P3;
                end else if (dscore < PLAYER_STAND_MIN) begin
                    w_next = ST_DEAL_D3;
                end else begin
                    w_next = ST_RESULT;
                end
            end
            ST_DEAL_P3: begin
                load_pcard3 = 1'b1;
                w_next      = ST_DECIDE_D3;
            end
            ST_DECIDE_D3: begin
                w_next = w_dealer_draw ? ST_DEAL_D3 : ST_RESULT;
            end
            ST_DEAL_D3: begin
                load_dcard3 = 1'b1;
                w_next      = ST_RESULT;
            end
            ST_RESULT: begin
                player_win_light = (pscore >= dscore);
                dealer_win_light = (dscore >= pscore);
                w_next           = ST_RESULT;
            end
            default: begin
                w_next = ST_DEAL_P1;
            end
        endcase
    end

`ifdef DEAL_SEQ_STATE_OUT_EN
    assign state_out = r_state;
`endif

endmodule
